// File: rtl/linfan_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
package linfan_pkg;

    localparam int BIN_W_DEF  = 14;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_MAX    = 9999;

    // Saturated display value used when the input exceeds BCD_MAX
    localparam logic [4*BCD_DIGITS-1:0] BCD_SAT = 16'h9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_adj3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // +3 correction for digits >= 5
    always_comb begin
        dout = din;
        if (din >= 4'd5)
            dout = din + 4'd3;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Optional macro BIN2BCD_SAT_EN: when defined, an overflowing input shows as
// 9999 on bcd; otherwise bcd carries the low four digits (bin mod 10000).
module bin2bcd_seq #(
    parameter int BIN_W = linfan_pkg::BIN_W_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [BIN_W-1:0]                    bin,
    output logic                                busy,
    output logic                                done,
    output logic [4*linfan_pkg::BCD_DIGITS-1:0] bcd,
    output logic                                ovf
);
    import linfan_pkg::*;

    // Four BCD digits plus one overflow bit (max 16383 -> 1_6383)
    localparam int DIG_W = 4 * BCD_DIGITS;
    localparam int ACC_W = DIG_W + 1;
    localparam int CNT_W = $clog2(BIN_W);

    state_t             state;
    logic [BIN_W-1:0]   sreg;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [DIG_W-1:0]   adj;

    // Per-digit +3 correction on the current accumulator
    genvar g;
    generate
        for (g = 0; g < BCD_DIGITS; g++) begin : g_adj
            bcd_adj3 u_adj (
                .din  (acc[4*g +: 4]),
                .dout (adj[4*g +: 4])
            );
        end
    endgenerate

    // Conversion FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sreg  <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sreg  <= bin;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The old top bit is always zero before the last shift,
                    // so dropping it loses nothing.
                    {acc, sreg} <= {adj, sreg, 1'b0};
                    cnt         <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BIN_W - 1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    ovf <= acc[ACC_W-1];
`ifdef BIN2BCD_SAT_EN
                    bcd <= acc[ACC_W-1] ? BCD_SAT : acc[DIG_W-1:0];
`else
                    bcd <= acc[DIG_W-1:0];
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: cycle-level reference model plus
// directed literal checks; works with or without BIN2BCD_SAT_EN.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    bin2bcd_seq #(.BIN_W(14)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decimal digits of x as packed BCD
    function automatic logic [15:0] to_bcd(input int x);
        logic [15:0] r;
        int v;
        v = x;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference model: a request taken while idle completes 15 edges later
    logic        m_busy, m_done, m_ovf;
    logic [15:0] m_bcd;
    int          m_cnt, m_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_bcd = '0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == 15) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_ovf  = (m_val > 9999);
                    m_bcd  = (SAT && m_ovf) ? to_bcd(9999) : to_bcd(m_val % 10000);
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_val  = int'(bin);
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(posedge clk) begin
        #3;
        if (!rst) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("bcd",  bcd,  m_bcd);
            chk("ovf",  ovf,  m_ovf);
            if (done) done_cnt++;
        end
    end

    // Issue one request and wait for done; mode 0 quiet, 1 random noise, 2 scripted retriggers
    task automatic run_one(input logic [13:0] v, input int mode, output int lat, output int bcyc);
        start = 1'b1;
        bin   = v;
        lat   = -1;
        bcyc  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bcyc++;
            case (mode)
                1: begin start = 1'($urandom_range(0, 1)); bin = 14'($urandom); end
                2: begin start = (i == 4 || i == 14); bin = 14'd77; end
                default: begin start = 1'b0; bin = 14'($urandom); end
            endcase
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL timeout: no done for bin=%0d within 40 cycles", v);
        end
    endtask

    task automatic conv_chk(input logic [13:0] v, input logic [15:0] eb, input logic eo, input string nm);
        int lat, bc;
        run_one(v, 0, lat, bc);
        start = 1'b0;
        chk({nm, "_lat"}, lat, 15);
        chk({nm, "_bcd"}, bcd, eb);
        chk({nm, "_ovf"}, ovf, eo);
    endtask

    initial begin
        int lat, bc, d0;
        rst = 1'b1; start = 1'b0; bin = '0;
        @(posedge clk); #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd",  bcd,  0);
        chk("rst_ovf",  ovf,  0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed values with hand-computed results
        conv_chk(14'd0,     16'h0000, 1'b0, "zero");
        conv_chk(14'd1234,  16'h1234, 1'b0, "v1234");
        conv_chk(14'd9999,  16'h9999, 1'b0, "v9999");
        conv_chk(14'd10000, SAT ? 16'h9999 : 16'h0000, 1'b1, "v10000");
        conv_chk(14'd16383, SAT ? 16'h9999 : 16'h6383, 1'b1, "v16383");
        repeat (3) @(negedge clk);

        // Retriggers during SHIFT and DONE are ignored
        d0 = done_cnt;
        run_one(14'd42, 2, lat, bc);
        start = 1'b0;
        chk("retrig_bcd",  bcd, 16'h0042);
        chk("retrig_busy", bc, 15);
        chk("retrig_lat",  lat, 15);
        repeat (20) @(negedge clk);
        chk("retrig_dones", done_cnt - d0, 1);
        chk("retrig_idle",  busy, 0);

        // Reset in the middle of a conversion aborts it
        start = 1'b1; bin = 14'd5555;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_dones", done_cnt - d0, 0);
        chk("abort_bcd",   bcd, 16'h0000);
        chk("abort_busy",  busy, 0);
        conv_chk(14'd5555, 16'h5555, 1'b0, "v5555");

        // Back-to-back sweep: edges plus random values with noisy start
        d0 = done_cnt;
        begin
            int n;
            n = 0;
            for (int k = 0; k < 1500; k++) begin
                logic [13:0] v;
                if (k < 8) v = 14'(9996 + k);
                else if (k < 12) v = 14'(16380 + (k - 8));
                else v = 14'($urandom);
                run_one(v, 1, lat, bc);
                n++;
                if (lat >= 0) chk("sweep_lat", lat, 15);
            end
            start = 1'b0;
            repeat (20) @(negedge clk);
            chk("sweep_dones", done_cnt - d0, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
